ula_serial_ctrl: RTL and testbench

- Initiator/sequencer that drives the team's 2-bit ALU slice: INVA/ENA/ENB/F0/F1 controls, 2-bit A/B operands and carry-in.
- Executes one WIDTH-bit operation as WIDTH/2 consecutive slice steps, LSB pair first, chaining the slice carry through a register.
- Collects the result and the final carry, then reports completion with a start/busy/done handshake.
- Lets the datapath do full-width arithmetic and logic on the existing 2-bit slice without more combinational slices.

---
 rtl/ula_serial_ctrl.sv | 139 +++++++++++++
 tb/tb_ula_serial_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_serial_ctrl.sv
// Bit-serial sequencer for the 2-bit ALU slice: one WIDTH-bit operation in WIDTH/2 steps.
// Optional macro ULA_SERIAL_ZERO_FLAG_EN adds a registered zero-result flag.
module ula_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
`ifdef ULA_SERIAL_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             sl_inva,
    output logic             sl_ena,
    output logic             sl_enb,
    output logic             sl_f0,
    output logic             sl_f1,
    output logic [1:0]       sl_a,
    output logic [1:0]       sl_b,
    output logic             sl_cin,
    input  logic [1:0]       sl_out,
    input  logic             sl_cout
);
    localparam int N  = WIDTH / 2;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [4:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             cin_reg;
    logic             carry_reg;
    logic [KW-1:0]    k_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic             cout_reg;
    logic             busy_reg;
    logic             done_reg;
`ifdef ULA_SERIAL_ZERO_FLAG_EN
    logic             zero_reg;
    assign zero = zero_reg;
`endif

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign cout   = cout_reg;

    // Only the bit-pair addressed by the current step takes the slice output.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pair
            assign result_next[2*gi+1:2*gi] = (k_reg == KW'(gi)) ? sl_out
                                                                 : result_reg[2*gi+1:2*gi];
        end
    endgenerate

    // Slice drive comes from registered state only; operands shift so bits [1:0] are the current pair.
    always_comb begin
        sl_inva = 1'b0;
        sl_ena  = 1'b0;
        sl_enb  = 1'b0;
        sl_f0   = 1'b0;
        sl_f1   = 1'b0;
        sl_a    = 2'b00;
        sl_b    = 2'b00;
        sl_cin  = 1'b0;
        if (state_reg == RUN) begin
            {sl_inva, sl_ena, sl_enb, sl_f0, sl_f1} = op_reg;
            sl_a   = a_reg[1:0];
            sl_b   = b_reg[1:0];
            sl_cin = (k_reg == '0) ? cin_reg : carry_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cin_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            k_reg      <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef ULA_SERIAL_ZERO_FLAG_EN
            zero_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg    <= op;
                        a_reg     <= a;
                        b_reg     <= b;
                        cin_reg   <= cin;
                        k_reg     <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    carry_reg  <= sl_cout;
                    k_reg      <= k_reg + 1'b1;
                    a_reg      <= a_reg >> 2;
                    b_reg      <= b_reg >> 2;
                    if (k_reg == LAST) begin
                        cout_reg  <= sl_cout;
`ifdef ULA_SERIAL_ZERO_FLAG_EN
                        zero_reg  <= (result_next == '0);
`endif
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Bench for ula_serial_ctrl: 2-bit slice model, operation-level reference model with per-cycle compare,
// plus directed vectors with literal expectations.
module tb_ula_serial_ctrl;
    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    // Op word is {INVA, ENA, ENB, F0, F1}; F0F1: 00 AND, 01 OR, 10 NOT B, 11 SUM.
    localparam logic [4:0] OP_ADD  = 5'b01111;
    localparam logic [4:0] OP_SUB  = 5'b11111;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_OR   = 5'b01101;
    localparam logic [4:0] OP_NOTB = 5'b00110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, cin;
    logic [4:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, cout;
    logic [WIDTH-1:0] result;
`ifdef ULA_SERIAL_ZERO_FLAG_EN
    logic             zero;
`endif
    logic             sl_inva, sl_ena, sl_enb, sl_f0, sl_f1, sl_cin, sl_cout;
    logic [1:0]       sl_a, sl_b, sl_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc[$];
    logic [1:0] sla_q[$];

    ula_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout),
`ifdef ULA_SERIAL_ZERO_FLAG_EN
        .zero(zero),
`endif
        .sl_inva(sl_inva), .sl_ena(sl_ena), .sl_enb(sl_enb), .sl_f0(sl_f0), .sl_f1(sl_f1),
        .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin), .sl_out(sl_out), .sl_cout(sl_cout)
    );

    // 2-bit slice: carry always comes from the adder, whatever the function select.
    logic [1:0] s_ap, s_bp, s_o;
    logic       s_c;
    always_comb begin
        s_ap = (sl_ena ? sl_a : 2'b00) ^ {2{sl_inva}};
        s_bp = sl_enb ? sl_b : 2'b00;
        s_c  = sl_cin;
        s_o  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            case ({sl_f0, sl_f1})
                2'b00:   s_o[i] = s_ap[i] & s_bp[i];
                2'b01:   s_o[i] = s_ap[i] | s_bp[i];
                2'b10:   s_o[i] = ~s_bp[i];
                default: s_o[i] = s_ap[i] ^ s_bp[i] ^ s_c;
            endcase
            s_c = (s_ap[i] & s_bp[i]) | (s_c & (s_ap[i] ^ s_bp[i]));
        end
    end
    assign sl_out  = s_o;
    assign sl_cout = s_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] eff_a(input logic [4:0] o, input logic [WIDTH-1:0] x);
        return (o[3] ? x : '0) ^ {WIDTH{o[4]}};
    endfunction

    function automatic logic [WIDTH-1:0] eff_b(input logic [4:0] o, input logic [WIDTH-1:0] y);
        return o[2] ? y : '0;
    endfunction

    // Whole-word result: {carry-out, result}.
    function automatic logic [WIDTH:0] model_op(input logic [4:0] o, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y, input logic c);
        logic [WIDTH-1:0] ea, eb, r;
        logic [WIDTH:0]   s;
        ea = eff_a(o, x);
        eb = eff_b(o, y);
        s  = {1'b0, ea} + {1'b0, eb} + (WIDTH+1)'(c);
        case (o[1:0])
            2'b00:   r = ea & eb;
            2'b01:   r = ea | eb;
            2'b10:   r = ~eb;
            default: r = s[WIDTH-1:0];
        endcase
        return {s[WIDTH], r};
    endfunction

    // Reference model state: m_t = 0 idle, 1..N run steps, N+1 done cycle.
    int               m_t = 0;
    bit               m_valid = 1'b0;
    logic [4:0]       m_op;
    logic [WIDTH-1:0] m_a, m_b, m_res;
    logic             m_cin, m_cout, m_zero;

    // Carry entering step k is the carry of the low 2k bits of the full-width sum.
    function automatic logic carry_into(input int k);
        logic [WIDTH:0] msk, s;
        if (k == 0) return m_cin;
        msk = (WIDTH+1)'((1 << (2*k)) - 1);
        s = ({1'b0, eff_a(m_op, m_a)} & msk) + ({1'b0, eff_b(m_op, m_b)} & msk) + (WIDTH+1)'(m_cin);
        return s[2*k];
    endfunction

    always @(posedge clk) begin
        logic [WIDTH:0] full;
        cyc = cyc + 1;
        if (rst) begin
            m_valid = 1'b1;
            m_t = 0; m_res = '0; m_cout = 1'b0; m_zero = 1'b0;
        end else if (m_valid) begin
            if (m_t == 0) begin
                if (start) begin
                    m_op = op; m_a = a; m_b = b; m_cin = cin; m_t = 1;
                end
            end else if (m_t <= N) begin
                m_t = m_t + 1;
                if (m_t == N + 1) begin
                    full   = model_op(m_op, m_a, m_b, m_cin);
                    m_res  = full[WIDTH-1:0];
                    m_cout = full[WIDTH];
                    m_zero = (full[WIDTH-1:0] == '0);
                end
            end else begin
                m_t = 0;
            end
        end
    end

    always @(negedge clk) begin
        int k;
        if (m_valid) begin
            check("busy", busy, (m_t >= 1));
            check("done", done, (m_t == N + 1));
            if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
            if (m_t >= 1 && m_t <= N) begin
                k = m_t - 1;
                check("sl_ctrl", {sl_inva, sl_ena, sl_enb, sl_f0, sl_f1}, m_op);
                check("sl_a", sl_a, m_a[2*k +: 2]);
                check("sl_b", sl_b, m_b[2*k +: 2]);
                check("sl_cin", sl_cin, carry_into(k));
                sla_q.push_back(sl_a);
            end else begin
                check("sl_quiet", {sl_inva, sl_ena, sl_enb, sl_f0, sl_f1, sl_a, sl_b, sl_cin}, 0);
                check("result", result, m_res);
                check("cout", cout, m_cout);
`ifdef ULA_SERIAL_ZERO_FLAG_EN
                check("zero", zero, m_zero);
`endif
            end
        end
    end

    task automatic run_op(input string name, input logic [4:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic c,
                          input logic [WIDTH-1:0] er, input logic ec);
        int  c0;
        bit  seen;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y; cin = c; c0 = cyc;
        sla_q.delete();
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = ~x; b = ~y; cin = ~c;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_latency"}, cyc - c0, N + 1);
        check({name, "_result"}, result, er);
        check({name, "_cout"}, cout, ec);
        $display("op %s: a=%02h b=%02h cin=%0d -> result=%02h cout=%0d", name, x, y, c, result, cout);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int c0, d0;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);

        run_op("add", OP_ADD, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        check("add_sla_n", sla_q.size(), 4);
        if (sla_q.size() == 4) begin
            check("add_sla0", sla_q[0], 2);
            check("add_sla1", sla_q[1], 2);
            check("add_sla2", sla_q[2], 1);
            check("add_sla3", sla_q[3], 1);
        end
        run_op("carry", OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
`ifdef ULA_SERIAL_ZERO_FLAG_EN
        check("carry_zero", zero, 1);
`endif
        run_op("sub", OP_SUB, 8'h05, 8'h09, 1'b1, 8'h04, 1'b1);
        run_op("and", OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b1);
        run_op("or", OP_OR, 8'hA0, 8'h05, 1'b0, 8'hA5, 1'b0);
        run_op("notb", OP_NOTB, 8'h00, 8'h0F, 1'b0, 8'hF0, 1'b0);
`ifdef ULA_SERIAL_ZERO_FLAG_EN
        check("notb_zero", zero, 0);
`endif

        // start held for 8 cycles: one op at cycle 0, the next only after DONE.
        @(posedge clk); #1;
        start = 1'b1; op = OP_ADD; a = 8'h11; b = 8'h22; cin = 1'b0;
        c0 = cyc; d0 = done_cnt; done_cyc.delete();
        repeat (8) @(negedge clk);
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(negedge clk);
        check("hold_done_count", done_cnt - d0, 2);
        if (done_cyc.size() == 2) begin
            check("hold_done1_cycle", done_cyc[0] - c0, 5);
            check("hold_done2_cycle", done_cyc[1] - c0, 11);
        end
        check("hold_result", result, 8'h33);
        $display("handshake: %0d done pulses, result=%02h", done_cnt - d0, result);

        // Reset in cycle 3 of an operation.
        @(posedge clk); #1;
        start = 1'b1; op = OP_ADD; a = 8'h12; b = 8'h34; cin = 1'b0; d0 = done_cnt;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_cout", cout, 0);
        check("abort_sl", {sl_inva, sl_ena, sl_enb, sl_f0, sl_f1, sl_a, sl_b, sl_cin}, 0);
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        $display("abort: busy=%0d result=%02h extra done=%0d", busy, result, done_cnt - d0);

        run_op("post_abort", OP_ADD, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
